// File: rtl/spi_bus_arbiter_if.sv
// Shared-SPI arbiter bundle: two master request/grant pairs, their SPI pins,
// and the physical bus pins toward the flash (cs0) and RAM (cs1) devices.
interface spi_bus_arbiter_if;
  logic req0, req1;
  logic gnt0, gnt1;
  logic m0_clk, m0_cs_n, m0_mosi, m0_miso;
  logic m1_clk, m1_cs_n, m1_mosi, m1_miso;
  logic spi_clk, spi_mosi, spi_miso;
  logic spi_cs0_n, spi_cs1_n;
  logic busy, timeout;

  modport slave (
    input  req0, req1,
    input  m0_clk, m0_cs_n, m0_mosi,
    input  m1_clk, m1_cs_n, m1_mosi,
    input  spi_miso,
    output gnt0, gnt1, m0_miso, m1_miso,
    output spi_clk, spi_mosi, spi_cs0_n, spi_cs1_n,
    output busy, timeout
  );

  modport master (
    output req0, req1,
    output m0_clk, m0_cs_n, m0_mosi,
    output m1_clk, m1_cs_n, m1_mosi,
    output spi_miso,
    input  gnt0, gnt1, m0_miso, m1_miso,
    input  spi_clk, spi_mosi, spi_cs0_n, spi_cs1_n,
    input  busy, timeout
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus between a flash reader (master 0)
// and a RAM controller (master 1), with idle gap and optional hold timeout.
//
// state  | meaning
// IDLE   | bus released, arbitrating pending requests
// GRANT0 | master 0 owns the bus
// GRANT1 | master 1 owns the bus
// GAP    | enforced idle time after a grant ends (release or timeout)
module spi_bus_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD   = 4096
) (
  input logic           clk,
  input logic           reset_n,
  spi_bus_arbiter_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  state_t              state, state_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt, hold_inc;
  logic                last_gnt, last_nxt;
  logic                timeout_q, timeout_nxt;
  logic                started;
  logic                cur_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      hold_cnt  <= '0;
      last_gnt  <= 1'b1;
      timeout_q <= 1'b0;
      started   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      hold_cnt  <= hold_nxt;
      last_gnt  <= last_nxt;
      timeout_q <= timeout_nxt;
      started   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    hold_nxt    = hold_cnt;
    last_nxt    = last_gnt;
    timeout_nxt = 1'b0;
    cur_req     = 1'b0;
    hold_inc    = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);

    case (state)
      IDLE: begin
        // the first edge after reset only arms the arbiter
        if (started) begin
          if (bus.req0 && (!bus.req1 || last_gnt)) begin
            state_nxt = GRANT0;
            last_nxt  = 1'b0;
            hold_nxt  = '0;
          end else if (bus.req1) begin
            state_nxt = GRANT1;
            last_nxt  = 1'b1;
            hold_nxt  = '0;
          end
        end
      end
      GRANT0, GRANT1: begin
        cur_req  = (state == GRANT0) ? bus.req0 : bus.req1;
        hold_nxt = hold_inc;
        if (!cur_req) begin
          state_nxt = GAP;
          gap_nxt   = GAP_LOAD;
        end else if ((MAX_HOLD != 0) && (hold_inc == HOLD_MAX)) begin
          state_nxt   = GAP;
          gap_nxt     = GAP_LOAD;
          timeout_nxt = 1'b1;
          last_nxt    = (state == GRANT1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bus steering depends only on the state register, never on req inputs
  logic sel0, sel1;
  assign sel0 = (state == GRANT0);
  assign sel1 = (state == GRANT1);

  assign bus.gnt0      = sel0;
  assign bus.gnt1      = sel1;
  assign bus.busy      = (state != IDLE);
  assign bus.timeout   = timeout_q;
  assign bus.spi_clk   = (sel0 & bus.m0_clk)  | (sel1 & bus.m1_clk);
  assign bus.spi_mosi  = (sel0 & bus.m0_mosi) | (sel1 & bus.m1_mosi);
  assign bus.spi_cs0_n = sel0 ? bus.m0_cs_n : 1'b1;
  assign bus.spi_cs1_n = sel1 ? bus.m1_cs_n : 1'b1;
  assign bus.m0_miso   = sel0 & bus.spi_miso;
  assign bus.m1_miso   = sel1 & bus.spi_miso;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios plus random
// request traffic, compared every cycle against a behavioural bus-owner model.
module tb_spi_bus_arbiter;
  localparam int GAP = 2;
  localparam int MH  = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_bus_arbiter_if bus ();
  spi_bus_arbiter #(.GAP_CYCLES(GAP), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: who owns the bus, how long, how much gap remains
  int owner, gap_left, held, last;
  bit armed, exp_to;

  // DUT-observed grant history
  int  seq[$];
  bit  prev_g, have_prev;
  int  gapc, timeouts;
  bit  rq[2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; gap_left = 0; held = 0; last = 1; armed = 0; exp_to = 0;
    prev_g = 0; have_prev = 0; gapc = 0;
  endtask

  task automatic model_edge(input bit r0, input bit r1);
    bit r;
    exp_to = 0;
    if (owner >= 0) begin
      held++;
      r = (owner == 0) ? r0 : r1;
      if (!r || held == MH) begin
        exp_to   = r;
        last     = owner;
        owner    = -1;
        gap_left = (GAP == 0) ? 1 : GAP;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (armed && (r0 || r1)) begin
      owner = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
      last  = owner;
      held  = 0;
    end
    armed = 1;
  endtask

  task automatic drive_rand();
    bus.m0_clk   = 1'($urandom_range(0, 1));
    bus.m0_cs_n  = 1'($urandom_range(0, 1));
    bus.m0_mosi  = 1'($urandom_range(0, 1));
    bus.m1_clk   = 1'($urandom_range(0, 1));
    bus.m1_cs_n  = 1'($urandom_range(0, 1));
    bus.m1_mosi  = 1'($urandom_range(0, 1));
    bus.spi_miso = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all();
    logic e_clk, e_mosi, e_cs0, e_cs1, e_mi0, e_mi1;
    e_clk  = (owner == 0) ? bus.m0_clk  : (owner == 1) ? bus.m1_clk  : 1'b0;
    e_mosi = (owner == 0) ? bus.m0_mosi : (owner == 1) ? bus.m1_mosi : 1'b0;
    e_cs0  = (owner == 0) ? bus.m0_cs_n : 1'b1;
    e_cs1  = (owner == 1) ? bus.m1_cs_n : 1'b1;
    e_mi0  = (owner == 0) ? bus.spi_miso : 1'b0;
    e_mi1  = (owner == 1) ? bus.spi_miso : 1'b0;
    chk("gnt0",      bus.gnt0,      owner == 0);
    chk("gnt1",      bus.gnt1,      owner == 1);
    chk("busy",      bus.busy,      (owner >= 0) || (gap_left > 0));
    chk("timeout",   bus.timeout,   exp_to);
    chk("spi_clk",   bus.spi_clk,   e_clk);
    chk("spi_mosi",  bus.spi_mosi,  e_mosi);
    chk("spi_cs0_n", bus.spi_cs0_n, e_cs0);
    chk("spi_cs1_n", bus.spi_cs1_n, e_cs1);
    chk("m0_miso",   bus.m0_miso,   e_mi0);
    chk("m1_miso",   bus.m1_miso,   e_mi1);
  endtask

  task automatic track();
    bit g;
    g = bus.gnt0 | bus.gnt1;
    if (g && !prev_g) begin
      if (have_prev) chk_int("gap_len", gapc, GAP);
      have_prev = 1;
      seq.push_back(bus.gnt1 ? 1 : 0);
    end
    if (!g && bus.busy) gapc++;
    if (g) gapc = 0;
    prev_g = g;
    if (bus.timeout) timeouts++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(bus.req0, bus.req1);
    #1;
    drive_rand();
    #1;
    check_all();
    track();
  endtask

  task automatic apply_req();
    bus.req0 = rq[0];
    bus.req1 = rq[1];
  endtask

  // each owner holds for hold_len cycles, then drops; optionally re-requests
  task automatic run_rr(input int n, input int hold_len, input bit rearm);
    for (int i = 0; i < n; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (owner == m && held == hold_len - 1) rq[m] = 0;
        else if (rearm && !rq[m] && owner != m) rq[m] = 1;
      end
      apply_req();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    rq[0] = 0; rq[1] = 0; apply_req();
    drive_rand();
    model_reset();
    timeouts = 0;
    repeat (2) @(posedge clk);
    #2;
    drive_rand();
    #1;
    check_all();

    // contention straight out of reset: master 0 first, then master 1
    @(negedge clk);
    reset_n = 1'b1;
    rq[0] = 1; rq[1] = 1; apply_req();
    step();
    chk("no_grant_first_edge", bus.gnt0 | bus.gnt1, 1'b0);
    step();
    chk("contention_m0_first", bus.gnt0, 1'b1);
    run_rr(30, 5, 0);

    // single request
    rq[0] = 1; apply_req();
    repeat (6) step();
    rq[0] = 0; apply_req();
    repeat (5) step();

    // continuous round-robin with 8-cycle transactions
    seq.delete();
    rq[0] = 1; rq[1] = 1; apply_req();
    run_rr(80, 8, 1);
    chk_int("rr_grants", (seq.size() >= 4) ? 1 : 0, 1);
    for (int i = 1; i < seq.size(); i++) chk_int("rr_alt", seq[i], 1 - seq[i-1]);
    rq[0] = 0; rq[1] = 0; apply_req();
    repeat (12) step();

    // hold timeout on master 1 with master 0 pending
    rq[1] = 1; apply_req();
    for (int i = 0; i < 5 && !bus.gnt1; i++) step();
    chk("to_gnt1_reached", bus.gnt1, 1'b1);
    rq[0] = 1; apply_req();
    timeouts = 0;
    repeat (22) step();
    chk_int("to_pulses", timeouts, 1);
    chk("gnt0_after_to", bus.gnt0, 1'b1);
    rq[0] = 0; apply_req();
    repeat (6) step();
    chk("regrant1_after_to", bus.gnt1, 1'b1);
    rq[1] = 0; apply_req();
    repeat (20) step();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (owner == m) begin
          if ($urandom_range(0, 9) == 0) rq[m] = 0;
        end else if (!rq[m] && $urandom_range(0, 3) == 0) rq[m] = 1;
      end
      apply_req();
    end

    // asynchronous reset while master 1 holds the bus
    rq[0] = 0; rq[1] = 1; apply_req();
    for (int i = 0; i < 40 && !bus.gnt1; i++) step();
    chk("ar_gnt1_reached", bus.gnt1, 1'b1);
    step();
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("ar_gnt1_low", bus.gnt1, 1'b0);
    chk("ar_cs1_high", bus.spi_cs1_n, 1'b1);
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("ar_no_gnt_edge1", bus.gnt1, 1'b0);
    step();
    chk("ar_gnt1_edge2", bus.gnt1, 1'b1);
    rq[1] = 0; apply_req();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2: minimum number of idle cycles, with both chip selects high, between two grants.
REQ-002 Parameter MAX_HOLD, default 4096: maximum number of cycles one grant may last; 0 disables the timeout.
REQ-003 Port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports req0 / req1, input, 1 bit each: bus request from master 0 (flash reader) and master 1 (RAM controller); held high for the whole transaction.
REQ-006 Ports gnt0 / gnt1, output, 1 bit each: registered grant to master 0 and master 1; never both high.
REQ-007 Ports m0_clk, m0_cs_n, m0_mosi / m1_clk, m1_cs_n, m1_mosi, input, 1 bit each: SPI outputs of each master.
REQ-008 Ports m0_miso / m1_miso, output, 1 bit each: MISO returned to each master.
REQ-009 Ports spi_clk, spi_mosi, output, 1 bit each: shared physical SPI clock and data out.
REQ-010 Port spi_miso, input, 1 bit: shared physical SPI data in.
REQ-011 Ports spi_cs0_n / spi_cs1_n, output, 1 bit each: per-device chip selects (flash / RAM), active low.
REQ-012 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 Port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT0, GRANT1 and GAP.
REQ-015 In IDLE with exactly one request sampled high at edge N, the FSM SHALL enter the matching GRANTx, and gntx SHALL be high from the cycle after edge N.
REQ-016 In IDLE with both requests high, the arbiter SHALL grant the master not granted last (round-robin); after reset, master 0 SHALL win.
REQ-017 In GRANTx: spi_clk = mx_clk, spi_mosi = mx_mosi, spi_csx_n = mx_cs_n, other cs_n = 1, mx_miso = spi_miso, other master's miso = 0.
REQ-018 Outside GRANT states, spi_clk SHALL be 0, spi_mosi 0, both cs_n 1, and both miso outputs 0.
REQ-019 The bus mux SHALL be selected only by registered state, so the outputs are glitch-free with respect to the req inputs.
REQ-020 In GRANTx, reqx sampled low SHALL cause a transition to GAP, with gntx low in the next cycle.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, counted by a down-counter, then return to IDLE; with GAP_CYCLES = 0, GAP SHALL last 1 cycle.
REQ-022 Requests arriving during GRANT or GAP SHALL wait; they SHALL NOT be lost or pre-empt the current grant.
REQ-023 A hold counter SHALL count cycles in GRANTx.
REQ-024 If MAX_HOLD ≠ 0 and the hold count reaches MAX_HOLD while reqx is still high, the arbiter SHALL drop gntx, pulse timeout for 1 cycle, and enter GAP.
REQ-025 After a timeout, the timed-out master SHALL lose round-robin priority: last-grant is updated to it.
REQ-026 A master that keeps req high after a timeout SHALL be re-granted only when it wins arbitration again.
REQ-027 The hold counter width SHALL be clog2(MAX_HOLD+1), and the counter SHALL saturate rather than wrap.
REQ-028 A master SHALL drive mx_cs_n low only while gntx is high; the arbiter SHALL mask mx_cs_n to 1 when not granted regardless.

Reset
REQ-029 While reset_n is low (asynchronous): state = IDLE, gnt0 = gnt1 = 0, last-grant = master 1 (so master 0 wins first), counters = 0, timeout = 0, busy = 0.
REQ-030 While reset_n is low: spi_cs0_n = spi_cs1_n = 1, spi_clk = 0, spi_mosi = 0, both miso outputs = 0.
REQ-031 Reset asserted mid-transaction SHALL release the bus immediately, without waiting for a clock edge.
REQ-032 After reset_n deasserts, the first grant SHALL occur no earlier than the second clk edge.

Verification
REQ-033 Single request: req0 = 1 at cycle 0 -> gnt0 = 1 at cycle 1; spi_cs0_n follows m0_cs_n; m1_miso = 0.
REQ-034 Contention after reset: req0 = req1 = 1 together -> gnt0 first; req0 drops -> 2 GAP cycles with both cs_n = 1 -> gnt1.
REQ-035 Round-robin: both masters request continuously, each releasing after 8 cycles -> grants alternate 0,1,0,1 with a GAP of exactly GAP_CYCLES between each.
REQ-036 Timeout: MAX_HOLD = 16, req1 held high -> gnt1 drops after 16 cycles, timeout pulses once, GAP follows, then a pending req0 is granted.
REQ-037 Async reset mid-transfer: reset_n low while GRANT1 -> spi_cs1_n = 1 and gnt1 = 0 within the same cycle; after release, req1 -> gnt1 after 2 edges.
REQ-038 Isolation: toggle m1_clk and m1_cs_n while gnt0 = 1 -> spi_clk tracks only m0_clk and spi_cs1_n stays 1.
